// File: rtl/calendar_set_controller.sv
// calendar_set_controller: key-driven edit sequencer that shadows the calendar time and loads it back
module calendar_set_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 500000000,
  parameter int unsigned BLINK_HALF     = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_enter,
  input  logic       key_space,
  input  logic [6:0] cur_year,
  input  logic [3:0] cur_month,
  input  logic [4:0] cur_day,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       edit_mode,
  output logic [2:0] field_sel,
  output logic       blink,
  output logic       load,
  output logic [6:0] set_year,
  output logic [3:0] set_month,
  output logic [4:0] set_day,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec
);
  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] EDIT = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;
  logic [1:0]  state;
  logic [2:0]  enter_sync, space_sync;
  logic        enter_ev, space_ev, blink_q;
  logic [31:0] tcnt, bcnt;
  logic [6:0]  year_inc;
  logic [3:0]  month_inc;
  logic [4:0]  dim_cur, dim_y, dim_m, day_inc;
  function automatic logic [4:0] days_in(input logic [3:0] m, input logic [6:0] y);
    days_in = (m == 4'd2) ? ((y[1:0] == 2'b00) ? 5'd29 : 5'd28) :
              (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
  endfunction
  always_comb begin
    year_inc  = (set_year >= 7'd99) ? 7'd0 : set_year + 7'd1;
    month_inc = (set_month >= 4'd12) ? 4'd1 : set_month + 4'd1;
    dim_cur   = days_in(set_month, set_year);
    dim_y     = days_in(set_month, year_inc);
    dim_m     = days_in(month_inc, set_year);
    day_inc   = (set_day >= dim_cur) ? 5'd1 : set_day + 5'd1;
  end
  // two-flop synchronizer, then a registered rising-edge detect on the second flop
  always_ff @(posedge clk) begin
    if (rst) begin
      enter_sync <= '0;
      space_sync <= '0;
      enter_ev   <= 1'b0;
      space_ev   <= 1'b0;
    end else begin
      enter_sync <= {enter_sync[1:0], key_enter};
      space_sync <= {space_sync[1:0], key_space};
      enter_ev   <= enter_sync[1] & ~enter_sync[2];
      space_ev   <= space_sync[1] & ~space_sync[2];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      field_sel <= 3'd0;
      blink_q   <= 1'b0;
      tcnt      <= '0;
      bcnt      <= '0;
      set_year  <= 7'd0;
      set_month <= 4'd1;
      set_day   <= 5'd1;
      set_hour  <= 5'd0;
      set_min   <= 6'd0;
      set_sec   <= 6'd0;
    end else begin
      case (state)
        RUN: if (enter_ev) begin
          state     <= EDIT;
          field_sel <= 3'd0;
          tcnt      <= '0;
          bcnt      <= '0;
          blink_q   <= 1'b1;
          set_year  <= cur_year;
          set_month <= cur_month;
          set_day   <= cur_day;
          set_hour  <= cur_hour;
          set_min   <= cur_min;
          set_sec   <= cur_sec;
        end
        EDIT: begin
          if (enter_ev || space_ev) begin
            tcnt    <= '0;
            bcnt    <= '0;
            blink_q <= 1'b1;
          end else begin
            tcnt    <= tcnt + 32'd1;
            bcnt    <= (bcnt == BLINK_HALF - 32'd1) ? '0 : bcnt + 32'd1;
            blink_q <= (bcnt == BLINK_HALF - 32'd1) ? ~blink_q : blink_q;
          end
          // enter outranks space; timeout only when no key arrived
          if (enter_ev) begin
            if (field_sel == 3'd5) state <= LOAD;
            else field_sel <= field_sel + 3'd1;
          end else if (space_ev) begin
            case (field_sel)
              3'd0: begin
                set_year <= year_inc;
                set_day  <= (set_day > dim_y) ? dim_y : set_day;
              end
              3'd1: begin
                set_month <= month_inc;
                set_day   <= (set_day > dim_m) ? dim_m : set_day;
              end
              3'd2: set_day  <= day_inc;
              3'd3: set_hour <= (set_hour >= 5'd23) ? 5'd0 : set_hour + 5'd1;
              3'd4: set_min  <= (set_min >= 6'd59) ? 6'd0 : set_min + 6'd1;
              3'd5: set_sec  <= (set_sec >= 6'd59) ? 6'd0 : set_sec + 6'd1;
              default: ;
            endcase
          end else if (tcnt == TIMEOUT_CYCLES - 32'd1) begin
            state     <= RUN;
            field_sel <= 3'd0;
          end
        end
        LOAD: begin
          state     <= RUN;
          field_sel <= 3'd0;
        end
        default: state <= RUN;
      endcase
    end
  end
  assign edit_mode = (state == EDIT) || (state == LOAD);
  assign load      = (state == LOAD);
  assign blink     = blink_q && (state == EDIT);
endmodule
